// File: rtl/code_conv.sv
// Registered 4-bit code converter: binary<->Gray and BCD<->Excess-3 with an
// illegal-input flag. One cycle of latency; synchronous active-high reset.
module code_conv (
  input  logic       clk,
  input  logic       rst,
  input  logic       ain,
  input  logic       bin,
  input  logic       cin,
  input  logic       din,
  input  logic [1:0] mode,
  output logic       aout,
  output logic       bout,
  output logic       cout,
  output logic       dout,
  output logic       err
);

  typedef enum logic [1:0] {
    ModeBin2Gray = 2'b00,
    ModeGray2Bin = 2'b01,
    ModeBcd2Xs3  = 2'b10,
    ModeXs32Bcd  = 2'b11
  } mode_e;

  localparam logic [3:0] BcdMax = 4'd9;
  localparam logic [3:0] Xs3Min = 4'd3;
  localparam logic [3:0] Xs3Max = 4'd12;
  localparam logic [3:0] Xs3Off = 4'd3;

  logic [3:0] word_in;
  logic [3:0] word_d, word_q;
  logic       err_d, err_q;
  mode_e      mode_sel;

  assign word_in  = {ain, bin, cin, din};
  assign mode_sel = mode_e'(mode);

  always_comb begin
    word_d = 4'b0000;
    err_d  = 1'b0;
    unique case (mode_sel)
      ModeBin2Gray: begin
        word_d[3] = word_in[3];
        for (int n = 2; n >= 0; n--) begin
          word_d[n] = word_in[n+1] ^ word_in[n];
        end
      end
      ModeGray2Bin: begin
        // Each binary bit folds in the already-decoded bit above it.
        word_d[3] = word_in[3];
        for (int n = 2; n >= 0; n--) begin
          word_d[n] = word_d[n+1] ^ word_in[n];
        end
      end
      ModeBcd2Xs3: begin
        if (word_in <= BcdMax) begin
          word_d = word_in + Xs3Off;
        end else begin
          err_d = 1'b1;
        end
      end
      ModeXs32Bcd: begin
        if (word_in >= Xs3Min && word_in <= Xs3Max) begin
          word_d = word_in - Xs3Off;
        end else begin
          err_d = 1'b1;
        end
      end
      default: begin
        word_d = 4'b0000;
        err_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= 4'b0000;
      err_q  <= 1'b0;
    end else begin
      word_q <= word_d;
      err_q  <= err_d;
    end
  end

  assign aout = word_q[3];
  assign bout = word_q[2];
  assign cout = word_q[1];
  assign dout = word_q[0];
  assign err  = err_q;

endmodule

// File: tb/tb_code_conv.sv
// Self-checking bench for code_conv: arithmetic reference model checked every
// cycle, plus literal expectations for the documented code points.
module tb_code_conv;

  logic       clk = 1'b0;
  logic       rst;
  logic       ain, bin, cin, din;
  logic [1:0] mode;
  logic       aout, bout, cout, dout, err;

  int tests = 0;
  int fails = 0;

  logic [3:0] exp_o;
  logic       exp_err;
  logic       exp_valid = 1'b0;

  code_conv dut (
    .clk  (clk),
    .rst  (rst),
    .ain  (ain),
    .bin  (bin),
    .cin  (cin),
    .din  (din),
    .mode (mode),
    .aout (aout),
    .bout (bout),
    .cout (cout),
    .dout (dout),
    .err  (err)
  );

  always #5 clk = ~clk;

  // Returns {err, word}.
  function automatic logic [4:0] ref_conv(input logic [1:0] m, input logic [3:0] i);
    logic [3:0] o;
    logic       e;
    o = 4'b0000;
    e = 1'b0;
    case (m)
      2'b00: o = i ^ (i >> 1);
      2'b01: o = i ^ (i >> 1) ^ (i >> 2) ^ (i >> 3);
      2'b10: if (i <= 4'd9) o = i + 4'd3; else e = 1'b1;
      default: if (i >= 4'd3 && i <= 4'd12) o = i - 4'd3; else e = 1'b1;
    endcase
    return {e, o};
  endfunction

  function automatic logic [3:0] dut_word();
    return {aout, bout, cout, dout};
  endfunction

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got err=%b o=%b, want err=%b o=%b", name, got[4], got[3:0],
               want[4], want[3:0]);
    end
  endtask

  // Reference model: what the outputs must be after each rising edge.
  always @(posedge clk) begin
    if (rst === 1'b1) begin
      exp_o   = 4'b0000;
      exp_err = 1'b0;
    end else begin
      {exp_err, exp_o} = ref_conv(mode, {ain, bin, cin, din});
    end
    exp_valid = 1'b1;
  end

  // Per-cycle compare away from the active edge.
  always @(negedge clk) begin
    if (exp_valid) check("model", {err, dut_word()}, {exp_err, exp_o});
  end

  task automatic drive(input logic r, input logic [1:0] m, input logic [3:0] w);
    @(negedge clk);
    rst  = r;
    mode = m;
    {ain, bin, cin, din} = w;
  endtask

  task automatic pin(input string name, input logic [4:0] want);
    @(posedge clk);
    #1;
    check(name, {err, dut_word()}, want);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] g;
    rst  = 1'b1;
    mode = 2'b10;
    {ain, bin, cin, din} = 4'b1111;

    // Pin the model against hand-computed values.
    check("ref b2g 1011", ref_conv(2'b00, 4'b1011), 5'b0_1110);
    check("ref b2g 0111", ref_conv(2'b00, 4'b0111), 5'b0_0100);
    check("ref g2b 1110", ref_conv(2'b01, 4'b1110), 5'b0_1011);
    check("ref g2b 1000", ref_conv(2'b01, 4'b1000), 5'b0_1111);
    check("ref xs3 1001", ref_conv(2'b10, 4'b1001), 5'b0_1100);
    check("ref xs3 1010", ref_conv(2'b10, 4'b1010), 5'b1_0000);
    check("ref bcd 1100", ref_conv(2'b11, 4'b1100), 5'b0_1001);
    check("ref bcd 0010", ref_conv(2'b11, 4'b0010), 5'b1_0000);

    // Reset with an illegal input pending, then release.
    pin("reset c1", 5'b0_0000);
    pin("reset c2", 5'b0_0000);
    drive(1'b0, 2'b10, 4'b1111);
    pin("post-reset", 5'b1_0000);

    // Binary -> Gray, exhaustive.
    for (int i = 0; i < 16; i++) drive(1'b0, 2'b00, 4'(i));
    drive(1'b0, 2'b00, 4'b1011); pin("b2g 1011", 5'b0_1110);
    drive(1'b0, 2'b00, 4'b0111); pin("b2g 0111", 5'b0_0100);
    drive(1'b0, 2'b00, 4'b1111); pin("b2g 1111", 5'b0_1000);

    // Gray -> binary, exhaustive plus round trip against the original value.
    for (int i = 0; i < 16; i++) drive(1'b0, 2'b01, 4'(i));
    drive(1'b0, 2'b01, 4'b1110); pin("g2b 1110", 5'b0_1011);
    drive(1'b0, 2'b01, 4'b1000); pin("g2b 1000", 5'b0_1111);
    for (int b = 0; b < 16; b++) begin
      g = 4'(b) ^ (4'(b) >> 1);
      drive(1'b0, 2'b01, g);
      pin("roundtrip", {1'b0, 4'(b)});
    end

    // BCD <-> Excess-3 corners.
    drive(1'b0, 2'b10, 4'b0000); pin("xs3 0000", 5'b0_0011);
    drive(1'b0, 2'b10, 4'b0111); pin("xs3 0111", 5'b0_1010);
    drive(1'b0, 2'b10, 4'b1001); pin("xs3 1001", 5'b0_1100);
    drive(1'b0, 2'b10, 4'b1010); pin("xs3 1010", 5'b1_0000);
    drive(1'b0, 2'b10, 4'b1111); pin("xs3 1111", 5'b1_0000);
    drive(1'b0, 2'b11, 4'b0011); pin("bcd 0011", 5'b0_0000);
    drive(1'b0, 2'b11, 4'b1100); pin("bcd 1100", 5'b0_1001);
    drive(1'b0, 2'b11, 4'b0010); pin("bcd 0010", 5'b1_0000);
    drive(1'b0, 2'b11, 4'b1101); pin("bcd 1101", 5'b1_0000);
    for (int i = 0; i < 16; i++) drive(1'b0, 2'b10, 4'(i));
    for (int i = 0; i < 16; i++) drive(1'b0, 2'b11, 4'(i));

    // Toggling bits at periods 2/3/5/7 with mode rotating every 4 clocks.
    for (int t = 0; t < 84; t++) begin
      drive(1'b0, 2'((t / 4) % 4),
            {1'((t / 2) % 2), 1'((t / 3) % 2), 1'((t / 5) % 2), 1'((t / 7) % 2)});
    end

    // Mode and data change on the same edge.
    drive(1'b0, 2'b00, 4'b1011); pin("same-edge a", 5'b0_1110);
    drive(1'b0, 2'b10, 4'b0101); pin("same-edge b", 5'b0_1000);

    // Mid-run reset discards the conversion in flight.
    drive(1'b1, 2'b10, 4'b0110); pin("mid reset", 5'b0_0000);
    drive(1'b0, 2'b10, 4'b0110); pin("after mid reset", 5'b0_1001);

    // Random stimulus with between-edge glitches and occasional reset.
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      mode = 2'($urandom);
      {ain, bin, cin, din} = 4'($urandom);
      rst = 1'b0;
      #2;
      rst  = ($urandom_range(0, 15) == 0);
      mode = 2'($urandom);
      {ain, bin, cin, din} = 4'($urandom);
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
